wide_add_sequencer: RTL and testbench

Multi-cycle wide adder/subtractor controller that runs one shared 16-bit ripple-carry slice adder over `WORDS` consecutive cycles, least-significant slice first. It latches the operands, carries between slices through a registered carry, and presents the full result with a start/ready/done handshake. It sits between the lab top level (switch/register inputs) and the 16-bit adder datapath. It lets wide arithmetic reuse one slice instead of instantiating `WORDS` adders.

---
 rtl/wide_add_pkg.sv | 12 +
 rtl/ripple_adder.sv | 25 ++
 rtl/wide_add_sequencer.sv | 120 ++++++++++++
 tb/tb_wide_add_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// Shared types and constants for the wide add/subtract sequencer.
package wide_add_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } wadd_state_t;

endpackage

// File: rtl/ripple_adder.sv
// 16-bit ripple-carry slice adder, purely combinational.
module ripple_adder
    import wide_add_pkg::*;
(
    input  logic [SLICE_W-1:0] A,
    input  logic [SLICE_W-1:0] B,
    input  logic               c_in,
    output logic [SLICE_W-1:0] S,
    output logic               c_out
);

    logic carry;

    // Bit-serial carry chain across the slice.
    always_comb begin
        S     = '0;
        carry = c_in;
        for (int i = 0; i < SLICE_W; i++) begin
            S[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        c_out = carry;
    end

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide adder/subtractor that reuses one 16-bit slice adder over WORDS cycles,
// least-significant slice first, with a start/ready/done handshake.
//
//   state | meaning
//   IDLE  | Ready high, waiting for Start
//   RUN   | one slice per edge, carry held in carry_q
//   DONE  | result published, Done pulses for one cycle
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic                   Sub,
    input  logic [SLICE_W*WORDS-1:0] A,
    input  logic [SLICE_W*WORDS-1:0] B,
    output logic                   Ready,
    output logic                   Done,
    output logic [SLICE_W*WORDS-1:0] S,
    output logic                   Cout,
    output logic                   Overflow
);

    localparam int N     = SLICE_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    wadd_state_t        state;
    logic [N-1:0]       op_a;
    logic [N-1:0]       op_b;
    logic [N-1:0]       shadow;
    logic [N-1:0]       next_shadow;
    logic               carry_q;
    logic [IDX_W-1:0]   idx;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               last_slice;
    logic               ovf_next;

    assign slice_a    = op_a[idx*SLICE_W +: SLICE_W];
    assign slice_b    = op_b[idx*SLICE_W +: SLICE_W];
    assign last_slice = (idx == IDX_W'(WORDS - 1));

    ripple_adder u_slice (
        .A     (slice_a),
        .B     (slice_b),
        .c_in  (carry_q),
        .S     (slice_sum),
        .c_out (slice_cout)
    );

    // Shadow result with the current slice merged in, so the final edge can
    // publish the complete sum without an extra cycle.
    always_comb begin
        next_shadow = shadow;
        next_shadow[idx*SLICE_W +: SLICE_W] = slice_sum;
    end

    // op_b is already inverted for subtract, so the add-overflow rule applies.
    assign ovf_next = (op_a[N-1] == op_b[N-1]) && (next_shadow[N-1] != op_a[N-1]);

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            Ready    <= 1'b1;
            Done     <= 1'b0;
            S        <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
            idx      <= '0;
            carry_q  <= 1'b0;
            shadow   <= '0;
            op_a     <= '0;
            op_b     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        op_a    <= A;
                        op_b    <= Sub ? ~B : B;
                        carry_q <= Sub;
                        idx     <= '0;
                        Ready   <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    shadow  <= next_shadow;
                    carry_q <= slice_cout;
                    if (last_slice) begin
                        idx      <= '0;
                        S        <= next_shadow;
                        Cout     <= slice_cout;
                        Overflow <= ovf_next;
                        Done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    Ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    Done  <= 1'b0;
                    Ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer with WORDS=4 (64-bit operands).
module tb_wide_add_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;
    logic        ready;
    logic        done;
    logic [63:0] s;
    logic        cout;
    logic        overflow;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] exp_s_last;

    wide_add_sequencer #(.WORDS(4)) dut (
        .Clk      (clk),
        .Reset    (reset),
        .Start    (start),
        .Sub      (sub),
        .A        (a),
        .B        (b),
        .Ready    (ready),
        .Done     (done),
        .S        (s),
        .Cout     (cout),
        .Overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: plain 65-bit arithmetic and signed overflow rules.
    function automatic void model(input logic [63:0] av, input logic [63:0] bv, input logic sv,
                                  output logic [63:0] es, output logic ec, output logic ev);
        logic [64:0] r;
        if (sv) r = {1'b0, av} - {1'b0, bv};
        else    r = {1'b0, av} + {1'b0, bv};
        es = r[63:0];
        ec = sv ? (av >= bv) : r[64];
        if (sv) ev = (av[63] != bv[63]) && (es[63] != av[63]);
        else    ev = (av[63] == bv[63]) && (es[63] != av[63]);
    endfunction

    task automatic run_op(input string name, input logic [63:0] av, input logic [63:0] bv, input logic sv);
        logic [63:0] es;
        logic        ec;
        logic        ev;
        int          w;
        int          lat;
        int          low;
        model(av, bv, sv, es, ec, ev);
        w = 0;
        while (!ready && w < 20) begin
            tick();
            w++;
        end
        chk({name, "_idle_before"}, 64'(ready), 64'd1);
        a = av; b = bv; sub = sv; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~av; b = ~bv; sub = ~sv;
        low = 0;
        lat = 0;
        if (!ready) low++;
        while (!done && lat < 20) begin
            chk({name, "_s_hold"}, s, exp_s_last);
            tick();
            lat++;
            if (!ready) low++;
        end
        chk({name, "_latency"}, 64'(lat), 64'd4);
        chk({name, "_s"}, s, es);
        chk({name, "_cout"}, 64'(cout), 64'(ec));
        chk({name, "_ovf"}, 64'(overflow), 64'(ev));
        exp_s_last = es;
        w = 0;
        while (!ready && w < 20) begin
            tick();
            w++;
            if (!ready) low++;
        end
        chk({name, "_ready_low_cycles"}, 64'(low), 64'd5);
    endtask

    initial begin
        logic [63:0] av;
        logic [63:0] bv;
        logic        svr;
        logic [63:0] es;
        logic        ec;
        logic        ev;
        logic [63:0] q_s[$];
        logic        q_c[$];
        logic        q_v[$];
        int          busy;

        reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        exp_s_last = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_s", s, 64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
        chk("reset_ovf", 64'(overflow), 64'd0);

        run_op("carry16", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
        run_op("carry_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        run_op("sub_neg", 64'd5, 64'd7, 1'b1);
        run_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        run_op("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_op("rand", {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end

        // Start held high with operands changing every cycle.
        busy = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            start = (cyc < 50);
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom};
            svr = 1'($urandom_range(0, 1));
            a = av; b = bv; sub = svr;
            chk("hold_ready", 64'(ready), 64'(busy == 0));
            if (start && busy == 0) begin
                model(av, bv, svr, es, ec, ev);
                q_s.push_back(es);
                q_c.push_back(ec);
                q_v.push_back(ev);
                busy = 6;
            end
            tick();
            if (busy > 0) busy--;
            chk("hold_done", 64'(done), 64'(busy == 1));
            if (busy == 1 && q_s.size() > 0) begin
                es = q_s.pop_front();
                ec = q_c.pop_front();
                ev = q_v.pop_front();
                chk("hold_s", s, es);
                chk("hold_cout", 64'(cout), 64'(ec));
                chk("hold_ovf", 64'(overflow), 64'(ev));
                exp_s_last = es;
            end else begin
                chk("hold_s_stable", s, exp_s_last);
            end
        end
        start = 1'b0;

        // Reset while idx=2 aborts the operation.
        run_op("pre_abort", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0);
        a = 64'h1234_5678_9ABC_DEF0; b = 64'h1111_1111_1111_1111; sub = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_s_last = '0;
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_s", s, 64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        chk("abort_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_no_done", 64'(done), 64'd0);
        end

        // Reset and Start together: reset wins.
        a = 64'd3; b = 64'd4; sub = 1'b0;
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start_ready", 64'(ready), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_start_no_done", 64'(done), 64'd0);
        end
        run_op("after_rst_start", 64'd3, 64'd4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
